sdram_host_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares the single host interface of sdram_controller between two requesters.
- Accepts read/write requests on two req/ack ports and issues exactly one controller command at a time, driving wr_enable or rd_enable until the controller reports busy.
- Waits for each command to complete, routes captured read data back to the owning port, and times out hung transactions.
- Sits between the client logic and sdram_controller's wr_*/rd_*/busy/rd_ready pins.

---
 rtl/sdram_host_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
// rtl/sdram_host_arbiter.sv - two-port round-robin arbiter in front of sdram_controller host pins
module sdram_host_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] ctrl_wr_addr,
    output logic [DATA_W-1:0] ctrl_wr_data,
    output logic              ctrl_wr_enable,
    output logic [ADDR_W-1:0] ctrl_rd_addr,
    output logic              ctrl_rd_enable,
    input  logic [DATA_W-1:0] ctrl_rd_data,
    input  logic              ctrl_rd_ready,
    input  logic              ctrl_busy,
    output logic [1:0]        grant
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;      // 1 = port 1 was granted last
    logic              we_q, we_d;
    logic              rd_seen_q, rd_seen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic              p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic              p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;

    logic              any_req, pick_p1, sel_we, timeout_hit, rd_now, done, fail;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [CNT_W-1:0]  cnt_inc;

    // A tie goes to the port that did not win last time.
    assign any_req     = p0_req | p1_req;
    assign pick_p1     = p1_req & (~p0_req | ~last_q);
    assign sel_we      = pick_p1 ? p1_we : p0_we;
    assign sel_addr    = pick_p1 ? p1_addr : p0_addr;
    assign sel_wdata   = pick_p1 ? p1_wdata : p0_wdata;
    assign cnt_inc     = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_LIMIT);
    assign rd_now      = ~we_q & ctrl_rd_ready & ~rd_seen_q;

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            rd_seen_q   <= 1'b0;
            cnt_q       <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            we_q        <= we_d;
            rd_seen_q   <= rd_seen_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    // Next state: issue only when the controller is idle, finish on busy fall or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!ctrl_busy && any_req) state_d = ISSUE;
            ISSUE:     if (ctrl_busy) state_d = WAIT_DONE;
                       else if (timeout_hit) state_d = IDLE;
            WAIT_DONE: if (!ctrl_busy || timeout_hit) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Datapath and pulse outputs for the next cycle.
    always_comb begin
        grant_d     = grant_q;
        last_d      = last_q;
        we_d        = we_q;
        rd_seen_d   = rd_seen_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        done        = 1'b0;
        fail        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ctrl_busy && any_req) begin
                    grant_d   = pick_p1 ? 2'b10 : 2'b01;
                    last_d    = pick_p1;
                    we_d      = sel_we;
                    wr_addr_d = sel_addr;
                    rd_addr_d = sel_addr;
                    if (sel_we) wr_data_d = sel_wdata;
                    wr_en_d   = sel_we;
                    rd_en_d   = ~sel_we;
                    cnt_d     = '0;
                    rd_seen_d = 1'b0;
                end
            end
            ISSUE: begin
                if (ctrl_busy) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    done    = 1'b1;
                    fail    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (rd_now) begin
                    rd_seen_d = 1'b1;
                    if (grant_q[1]) begin
                        p1_rdata_d  = ctrl_rd_data;
                        p1_rvalid_d = 1'b1;
                    end else begin
                        p0_rdata_d  = ctrl_rd_data;
                        p0_rvalid_d = 1'b1;
                    end
                end
                if (!ctrl_busy) begin
                    done = 1'b1;
                    fail = ~we_q & ~rd_seen_q & ~rd_now;
                end else if (timeout_hit) begin
                    done = 1'b1;
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
        if (done) begin
            grant_d  = 2'b00;
            p0_ack_d = grant_q[0];
            p1_ack_d = grant_q[1];
            p0_err_d = grant_q[0] & fail;
            p1_err_d = grant_q[1] & fail;
        end
    end

    assign grant          = grant_q;
    assign ctrl_wr_addr   = wr_addr_q;
    assign ctrl_rd_addr   = rd_addr_q;
    assign ctrl_wr_data   = wr_data_q;
    assign ctrl_wr_enable = wr_en_q;
    assign ctrl_rd_enable = rd_en_q;
    assign p0_rdata       = p0_rdata_q;
    assign p1_rdata       = p1_rdata_q;
    assign p0_ack         = p0_ack_q;
    assign p1_ack         = p1_ack_q;
    assign p0_err         = p0_err_q;
    assign p1_err         = p1_err_q;
    assign p0_rvalid      = p0_rvalid_q;
    assign p1_rvalid      = p1_rvalid_q;
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb/tb_sdram_host_arbiter.sv - self-checking bench for sdram_host_arbiter
module tb_sdram_host_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p0_err, p0_rvalid, p1_ack, p1_err, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ctrl_wr_addr, ctrl_rd_addr;
    logic [DW-1:0] ctrl_wr_data, ctrl_rd_data;
    logic          ctrl_wr_enable, ctrl_rd_enable, ctrl_rd_ready, ctrl_busy;
    logic [1:0]    grant;

    sdram_host_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_enable(ctrl_wr_enable),
        .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_enable(ctrl_rd_enable), .ctrl_rd_data(ctrl_rd_data),
        .ctrl_rd_ready(ctrl_rd_ready), .ctrl_busy(ctrl_busy), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            en_cyc;
        logic          err;
        logic          rv;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t       sb0[$];
    exp_t       sb1[$];
    logic [1:0] exp_grant[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Controller model: busy rises m_delay cycles after an enable, stays m_len cycles.
    int            m_delay = 2, m_len = 10, m_rdy = -1, m_rdy2 = -1;
    bit            m_never = 1'b0;
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;
    initial begin : model
        int ph, k;
        ph = 0; k = 0;
        ctrl_busy = 1'b0; ctrl_rd_ready = 1'b0; ctrl_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            ctrl_rd_ready = 1'b0;
            if (rst) begin
                ph = 0; ctrl_busy = 1'b0;
            end else if (ph == 0) begin
                if ((ctrl_wr_enable || ctrl_rd_enable) && !m_never) begin ph = 1; k = 0; end
            end else if (ph == 1) begin
                k++;
                if (k >= m_delay) begin ctrl_busy = 1'b1; ph = 2; k = 0; end
            end else begin
                k++;
                if (k == m_rdy)  begin ctrl_rd_ready = 1'b1; ctrl_rd_data = m_d1; end
                if (k == m_rdy2) begin ctrl_rd_ready = 1'b1; ctrl_rd_data = m_d2; end
                if (k >= m_len)  begin ctrl_busy = 1'b0; ph = 0; end
            end
        end
    end

    // Output monitor: command check on enable rise, completion check on ack.
    logic en_now, en_prev = 1'b0, owner, rv0 = 1'b0, rv1 = 1'b0;
    int   en_cnt = 0, cur_en = 0;
    exp_t e;
    logic [1:0] g;
    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0; en_cnt = 0; rv0 = 1'b0; rv1 = 1'b0;
        end else begin
            en_now = ctrl_wr_enable | ctrl_rd_enable;
            if (en_now) chk("single_enable", ctrl_wr_enable & ctrl_rd_enable, 0);
            if (en_now && !en_prev) begin
                chk("grant_expected", exp_grant.size() != 0, 1);
                if (exp_grant.size() != 0) begin
                    g = exp_grant.pop_front();
                    chk("grant", grant, g);
                end
                owner = grant[1];
                chk("issue_has_entry", owner ? sb1.size() != 0 : sb0.size() != 0, 1);
                if (owner ? sb1.size() != 0 : sb0.size() != 0) begin
                    e = owner ? sb1[0] : sb0[0];
                    chk("cmd_dir", ctrl_wr_enable, e.we);
                    chk("wr_addr", ctrl_wr_addr, e.a);
                    chk("rd_addr", ctrl_rd_addr, e.a);
                    if (e.we) chk("wr_data", ctrl_wr_data, e.wd);
                    cur_en = e.en_cyc;
                end
                en_cnt = 1;
            end else if (en_now) begin
                en_cnt++;
            end else if (en_prev) begin
                chk("enable_cycles", en_cnt, cur_en);
            end
            en_prev = en_now;
            if (p0_rvalid) begin chk("p0_rvalid_once", rv0, 0); rv0 = 1'b1; end
            if (p1_rvalid) begin chk("p1_rvalid_once", rv1, 0); rv1 = 1'b1; end
            if (p0_ack) begin
                chk("p0_ack_expected", sb0.size() != 0, 1);
                if (sb0.size() != 0) begin
                    e = sb0.pop_front();
                    chk("p0_err", p0_err, e.err);
                    chk("p0_rvalid_seen", rv0, e.rv);
                    if (e.rv) chk("p0_rdata", p0_rdata, e.rd);
                    chk("grant_release", grant, 0);
                end
                rv0 = 1'b0;
            end
            if (p1_ack) begin
                chk("p1_ack_expected", sb1.size() != 0, 1);
                if (sb1.size() != 0) begin
                    e = sb1.pop_front();
                    chk("p1_err", p1_err, e.err);
                    chk("p1_rvalid_seen", rv1, e.rv);
                    if (e.rv) chk("p1_rdata", p1_rdata, e.rd);
                    chk("grant_release", grant, 0);
                end
                rv1 = 1'b0;
            end
        end
    end

    task automatic txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int en_cyc, input logic err, input logic rv, input logic [DW-1:0] rd,
                       input bit chk_lat);
        exp_t x;
        int   n;
        x.we = we; x.a = a; x.wd = wd; x.en_cyc = en_cyc; x.err = err; x.rv = rv; x.rd = rd;
        if (p == 0) begin
            sb0.push_back(x); p0_we = we; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            sb1.push_back(x); p1_we = we; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end
        if (chk_lat) begin
            @(negedge clk);
            chk("issue_latency", ctrl_wr_enable | ctrl_rd_enable, 1);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 0 ? p0_ack : p1_ack) && n < 200);
        chk("ack_within_budget", (p == 0 ? p0_ack : p1_ack), 1);
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_pulses", {p0_ack, p0_err, p0_rvalid, p1_ack, p1_err, p1_rvalid}, 0);
        chk("rst_enables", {ctrl_wr_enable, ctrl_rd_enable}, 0);
        chk("rst_grant", grant, 0);
        chk("rst_wr_addr", ctrl_wr_addr, 0);
        chk("rst_rd_addr", ctrl_rd_addr, 0);
        chk("rst_wr_data", ctrl_wr_data, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // single write
        m_delay = 2; m_len = 10; m_rdy = -1; m_rdy2 = -1;
        exp_grant.push_back(2'b01);
        txn(0, 1'b1, 24'hfedbed, 16'd3333, 3, 1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) @(negedge clk);

        // single read on port 1
        m_len = 5; m_rdy = 2; m_d1 = 16'hbbbb;
        exp_grant.push_back(2'b10);
        txn(1, 1'b0, 24'hbedfed, 16'h0, 3, 1'b0, 1'b1, 16'hbbbb, 1'b0);
        chk("p0_rdata_untouched", p0_rdata, 16'h0);
        repeat (2) @(negedge clk);

        // later rd_ready pulse in the same transaction is ignored
        m_rdy = 1; m_d1 = 16'h1234; m_rdy2 = 3; m_d2 = 16'h5678;
        exp_grant.push_back(2'b01);
        txn(0, 1'b0, 24'h000abc, 16'h0, 3, 1'b0, 1'b1, 16'h1234, 1'b0);
        m_rdy2 = -1;

        // rd_ready in the same cycle busy falls
        m_len = 4; m_rdy = 4; m_d1 = 16'hcafe;
        exp_grant.push_back(2'b10);
        txn(1, 1'b0, 24'h123456, 16'h0, 3, 1'b0, 1'b1, 16'hcafe, 1'b0);

        // read where busy falls without data
        m_rdy = -1;
        exp_grant.push_back(2'b01);
        txn(0, 1'b0, 24'h00beef, 16'h0, 3, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("p0_rdata_held", p0_rdata, 16'h1234);

        // controller never answers: timeout in ISSUE
        m_never = 1'b1;
        exp_grant.push_back(2'b01);
        txn(0, 1'b0, 24'h0f0f0f, 16'h0, TO, 1'b1, 1'b0, 16'h0, 1'b0);
        m_never = 1'b0;
        exp_grant.push_back(2'b10);
        txn(1, 1'b1, 24'h222222, 16'h7777, 3, 1'b0, 1'b0, 16'h0, 1'b0);

        // reset in WAIT_DONE
        m_delay = 1; m_len = 10;
        exp_grant.push_back(2'b01);
        sb0.push_back('{we: 1'b0, a: 24'h111111, wd: 16'h0, en_cyc: 2, err: 1'b0, rv: 1'b0, rd: 16'h0});
        p0_we = 1'b0; p0_addr = 24'h111111; p0_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ctrl_rd_enable && n < 20);
        do begin @(negedge clk); n++; end while (ctrl_rd_enable && n < 40);
        chk("reset_test_issued", n < 40, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        p0_req = 1'b0;
        sb0.delete();
        exp_grant.delete();
        repeat (4) @(negedge clk);

        // contention from reset: strict alternation starting with port 0
        m_delay = 1; m_len = 2;
        for (int i = 0; i < 3; i++) begin
            exp_grant.push_back(2'b01);
            exp_grant.push_back(2'b10);
        end
        fork
            begin
                txn(0, 1'b1, 24'h000100, 16'h0100, 2, 1'b0, 1'b0, 16'h0, 1'b0);
                txn(0, 1'b1, 24'h000101, 16'h0101, 2, 1'b0, 1'b0, 16'h0, 1'b0);
                txn(0, 1'b1, 24'h000102, 16'h0102, 2, 1'b0, 1'b0, 16'h0, 1'b0);
            end
            begin
                txn(1, 1'b1, 24'h000200, 16'h0200, 2, 1'b0, 1'b0, 16'h0, 1'b0);
                txn(1, 1'b1, 24'h000201, 16'h0201, 2, 1'b0, 1'b0, 16'h0, 1'b0);
                txn(1, 1'b1, 24'h000202, 16'h0202, 2, 1'b0, 1'b0, 16'h0, 1'b0);
            end
        join
        repeat (3) @(negedge clk);
        chk("grants_consumed", exp_grant.size(), 0);
        chk("acks_consumed", sb0.size() + sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
